// File: rtl/ecap5_dwbarb.sv
// rtl/ecap5_dwbarb.sv - two-master pipelined Wishbone arbiter with throttle, abort and time-out status
module ecap5_dwbarb #(
  parameter int FIXED_PRIORITY  = 0,
  parameter int MAX_OUTSTANDING = 15,
  parameter int TIMEOUT         = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_cyc_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_stall_i,
  output logic [1:0]  grant_o,
  output logic        abort_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [15:0] TMO     = 16'(TIMEOUT);
  localparam logic        FIXED   = (FIXED_PRIORITY != 0);
  localparam logic        TMO_EN  = (TIMEOUT != 0);

  state_t      state_q;
  logic        last_q;
  logic [3:0]  outstanding_q, outstanding_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0] tmo_inc;
  logic [1:0]  grant_q;
  logic        abort_q;
  logic        timeout_q, timeout_d;
  logic        own0, own1, throttle, ack_valid, accept;

  assign own0     = (state_q == GNT0);
  assign own1     = (state_q == GNT1);
  assign throttle = (outstanding_q == MAX_OUT);
  // Acks with nothing outstanding are stale (e.g. after an abort) and are swallowed.
  assign ack_valid = s_wb_ack_i && (outstanding_q != 4'd0);
  assign accept    = s_wb_stb_o && !s_wb_stall_i;

  always_comb begin
    s_wb_adr_o = 32'd0;
    s_wb_dat_o = 32'd0;
    s_wb_sel_o = 4'd0;
    s_wb_we_o  = 1'b0;
    s_wb_stb_o = 1'b0;
    s_wb_cyc_o = 1'b0;
    if (own0) begin
      s_wb_adr_o = m0_wb_adr_i;
      s_wb_dat_o = m0_wb_dat_i;
      s_wb_sel_o = m0_wb_sel_i;
      s_wb_we_o  = m0_wb_we_i;
      s_wb_stb_o = m0_wb_stb_i && !throttle;
      s_wb_cyc_o = m0_wb_cyc_i;
    end else if (own1) begin
      s_wb_adr_o = m1_wb_adr_i;
      s_wb_dat_o = m1_wb_dat_i;
      s_wb_sel_o = m1_wb_sel_i;
      s_wb_we_o  = m1_wb_we_i;
      s_wb_stb_o = m1_wb_stb_i && !throttle;
      s_wb_cyc_o = m1_wb_cyc_i;
    end
  end

  assign m0_wb_ack_o   = own0 && ack_valid;
  assign m0_wb_dat_o   = own0 ? s_wb_dat_i : 32'd0;
  assign m0_wb_stall_o = own0 ? (s_wb_stall_i || throttle) : 1'b1;
  assign m1_wb_ack_o   = own1 && ack_valid;
  assign m1_wb_dat_o   = own1 ? s_wb_dat_i : 32'd0;
  assign m1_wb_stall_o = own1 ? (s_wb_stall_i || throttle) : 1'b1;

  assign tmo_inc = tmo_cnt_q + 16'd1;

  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !ack_valid) outstanding_d = outstanding_q + 4'd1;
    else if (!accept && ack_valid) outstanding_d = outstanding_q - 4'd1;
    tmo_cnt_d = 16'd0;
    timeout_d = 1'b0;
    if (TMO_EN && (outstanding_q != 4'd0) && !ack_valid) begin
      if (tmo_inc == TMO) timeout_d = 1'b1;
      else tmo_cnt_d = tmo_inc;
    end
  end

  assign grant_o   = grant_q;
  assign abort_o   = abort_q;
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      outstanding_q <= 4'd0;
      tmo_cnt_q     <= 16'd0;
      grant_q       <= 2'b00;
      abort_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      abort_q       <= 1'b0;
      timeout_q     <= timeout_d;
      outstanding_q <= outstanding_d;
      tmo_cnt_q     <= tmo_cnt_d;
      case (state_q)
        IDLE: begin
          // On contention m0 wins under fixed priority or when m1 was served last.
          if (m0_wb_cyc_i && (!m1_wb_cyc_i || FIXED || last_q)) begin
            state_q <= GNT0;
            grant_q <= 2'b01;
          end else if (m1_wb_cyc_i) begin
            state_q <= GNT1;
            grant_q <= 2'b10;
          end
        end
        GNT0: begin
          if (!m0_wb_cyc_i) begin
            last_q        <= 1'b0;
            outstanding_q <= 4'd0;
            tmo_cnt_q     <= 16'd0;
            abort_q       <= (outstanding_q != 4'd0);
            state_q       <= m1_wb_cyc_i ? GNT1 : IDLE;
            grant_q       <= m1_wb_cyc_i ? 2'b10 : 2'b00;
          end
        end
        GNT1: begin
          if (!m1_wb_cyc_i) begin
            last_q        <= 1'b1;
            outstanding_q <= 4'd0;
            tmo_cnt_q     <= 16'd0;
            abort_q       <= (outstanding_q != 4'd0);
            state_q       <= m0_wb_cyc_i ? GNT0 : IDLE;
            grant_q       <= m0_wb_cyc_i ? 2'b01 : 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecap5_dwbarb.sv
// tb/tb_ecap5_dwbarb.sv - directed self-checking bench for ecap5_dwbarb
module tb_ecap5_dwbarb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat, s_rdat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack, s_stall;

  logic [31:0] m0_rdat, m1_rdat, s_adr, s_wdat;
  logic [3:0]  s_sel;
  logic        m0_ack, m0_stall, m1_ack, m1_stall, s_we, s_stb, s_cyc, abort, timeout;
  logic [1:0]  grant;

  logic [31:0] f_m0_rdat, f_m1_rdat, f_s_adr, f_s_wdat;
  logic [3:0]  f_s_sel;
  logic        f_m0_ack, f_m0_stall, f_m1_ack, f_m1_stall, f_s_we, f_s_stb, f_s_cyc, f_abort, f_timeout;
  logic [1:0]  f_grant;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ecap5_dwbarb #(.FIXED_PRIORITY(0), .MAX_OUTSTANDING(2), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_wdat), .m0_wb_sel_i(m0_sel), .m0_wb_we_i(m0_we),
    .m0_wb_stb_i(m0_stb), .m0_wb_cyc_i(m0_cyc),
    .m0_wb_dat_o(m0_rdat), .m0_wb_ack_o(m0_ack), .m0_wb_stall_o(m0_stall),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_wdat), .m1_wb_sel_i(m1_sel), .m1_wb_we_i(m1_we),
    .m1_wb_stb_i(m1_stb), .m1_wb_cyc_i(m1_cyc),
    .m1_wb_dat_o(m1_rdat), .m1_wb_ack_o(m1_ack), .m1_wb_stall_o(m1_stall),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat), .s_wb_sel_o(s_sel), .s_wb_we_o(s_we),
    .s_wb_stb_o(s_stb), .s_wb_cyc_o(s_cyc),
    .s_wb_dat_i(s_rdat), .s_wb_ack_i(s_ack), .s_wb_stall_i(s_stall),
    .grant_o(grant), .abort_o(abort), .timeout_o(timeout)
  );

  ecap5_dwbarb #(.FIXED_PRIORITY(1), .MAX_OUTSTANDING(2), .TIMEOUT(8)) dut_fp (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_wdat), .m0_wb_sel_i(m0_sel), .m0_wb_we_i(m0_we),
    .m0_wb_stb_i(m0_stb), .m0_wb_cyc_i(m0_cyc),
    .m0_wb_dat_o(f_m0_rdat), .m0_wb_ack_o(f_m0_ack), .m0_wb_stall_o(f_m0_stall),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_wdat), .m1_wb_sel_i(m1_sel), .m1_wb_we_i(m1_we),
    .m1_wb_stb_i(m1_stb), .m1_wb_cyc_i(m1_cyc),
    .m1_wb_dat_o(f_m1_rdat), .m1_wb_ack_o(f_m1_ack), .m1_wb_stall_o(f_m1_stall),
    .s_wb_adr_o(f_s_adr), .s_wb_dat_o(f_s_wdat), .s_wb_sel_o(f_s_sel), .s_wb_we_o(f_s_we),
    .s_wb_stb_o(f_s_stb), .s_wb_cyc_o(f_s_cyc),
    .s_wb_dat_i(s_rdat), .s_wb_ack_i(s_ack), .s_wb_stall_i(s_stall),
    .grant_o(f_grant), .abort_o(f_abort), .timeout_o(f_timeout)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h1234; s_ack = 1'b1; s_rdat = 32'hdead;
    #3;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (abort !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_pulses: got abort=%b timeout=%b expected 0 0", abort, timeout); end
    checks++; if ({s_cyc, s_stb, s_adr} !== 34'd0) begin errors++; $display("FAIL reset_slave: got cyc=%b stb=%b adr=%h expected all 0", s_cyc, s_stb, s_adr); end
    checks++; if ({m0_stall, m1_stall} !== 2'b11) begin errors++; $display("FAIL reset_stall: got %b%b expected 11", m0_stall, m1_stall); end
    checks++; if (m0_ack !== 1'b0 || m0_rdat !== 32'd0) begin errors++; $display("FAIL reset_resp: got ack=%b dat=%h expected 0 0", m0_ack, m0_rdat); end
    step;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_edge_grant: got %b expected 00", grant); end
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_adr = 32'd0; s_ack = 1'b0; s_rdat = 32'd0;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_arbitration;
    for (int r = 0; r < 4; r++) begin
      logic w;
      logic [31:0] exp_adr;
      w = r[0];
      exp_adr = w ? (32'hB000_0000 + r) : (32'hA000_0000 + r);
      step;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'hA000_0000 + r;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'hB000_0000 + r;
      step;
      checks++; if (grant !== (w ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", r, grant, w ? 2'b10 : 2'b01); end
      checks++; if (f_grant !== 2'b01) begin errors++; $display("FAIL fixed_grant[%0d]: got %b expected 01", r, f_grant); end
      checks++; if (s_adr !== exp_adr) begin errors++; $display("FAIL rr_adr[%0d]: got %h expected %h", r, s_adr, exp_adr); end
      checks++; if ((w ? m0_stall : m1_stall) !== 1'b1) begin errors++; $display("FAIL rr_loser_stall[%0d]: got 0 expected 1", r); end
      step;
      m0_stb = 1'b0; m1_stb = 1'b0;
      if (w) m0_cyc = 1'b0; else m1_cyc = 1'b0;
      s_ack = 1'b1; s_rdat = 32'hD0 + r;
      #1;
      checks++; if ((w ? m1_ack : m0_ack) !== 1'b1) begin errors++; $display("FAIL rr_ack[%0d]: got 0 expected 1", r); end
      checks++; if ((w ? m1_rdat : m0_rdat) !== 32'hD0 + r) begin errors++; $display("FAIL rr_dat[%0d]: got %h expected %h", r, w ? m1_rdat : m0_rdat, 32'hD0 + r); end
      step;
      s_ack = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0;
      step;
      checks++; if (grant !== 2'b00 || abort !== 1'b0) begin errors++; $display("FAIL rr_release[%0d]: got grant=%b abort=%b expected 00 0", r, grant, abort); end
    end
  endtask

  task automatic test_single;
    step;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_1000; m0_sel = 4'hF;
    #1;
    checks++; if (m0_stall !== 1'b1 || grant !== 2'b00 || s_cyc !== 1'b0) begin errors++; $display("FAIL single_req_cycle: got stall=%b grant=%b cyc=%b expected 1 00 0", m0_stall, grant, s_cyc); end
    step;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", grant); end
    checks++; if ({s_cyc, s_stb, m0_stall} !== 3'b110) begin errors++; $display("FAIL single_bus: got cyc=%b stb=%b stall=%b expected 1 1 0", s_cyc, s_stb, m0_stall); end
    checks++; if (s_adr !== 32'h0000_1000 || s_sel !== 4'hF) begin errors++; $display("FAIL single_adr: got %h sel %h expected 00001000 f", s_adr, s_sel); end
    for (int i = 0; i < 3; i++) begin
      step;
      m0_adr = 32'h0000_1000 + 32'(4 * (i + 1));
      if (i == 2) m0_stb = 1'b0;
      s_ack = 1'b1; s_rdat = 32'hC0DE_0000 + i;
      #1;
      checks++; if (m0_ack !== 1'b1 || m0_rdat !== 32'hC0DE_0000 + i) begin errors++; $display("FAIL single_read[%0d]: got ack=%b dat=%h expected 1 %h", i, m0_ack, m0_rdat, 32'hC0DE_0000 + i); end
      checks++; if (m1_ack !== 1'b0 || m1_rdat !== 32'd0) begin errors++; $display("FAIL single_other[%0d]: got ack=%b dat=%h expected 0 0", i, m1_ack, m1_rdat); end
    end
    step;
    s_ack = 1'b0; m0_cyc = 1'b0;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_hold: got %b expected 01", grant); end
    step;
    checks++; if (grant !== 2'b00 || abort !== 1'b0 || m0_stall !== 1'b1) begin errors++; $display("FAIL single_release: got grant=%b abort=%b stall=%b expected 00 0 1", grant, abort, m0_stall); end
  endtask

  task automatic test_handover;
    step;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h2000_0000;
    step;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h3000_0000;
    step;
    m0_stb = 1'b0; s_ack = 1'b1; s_rdat = 32'h55;
    #1;
    checks++; if (m1_stall !== 1'b1 || m0_ack !== 1'b1) begin errors++; $display("FAIL hand_wait: got m1_stall=%b m0_ack=%b expected 1 1", m1_stall, m0_ack); end
    step;
    s_ack = 1'b0; m0_cyc = 1'b0;
    step;
    checks++; if (grant !== 2'b10 || s_cyc !== 1'b1 || s_stb !== 1'b1) begin errors++; $display("FAIL hand_switch: got grant=%b cyc=%b stb=%b expected 10 1 1", grant, s_cyc, s_stb); end
    checks++; if (s_adr !== 32'h3000_0000 || abort !== 1'b0) begin errors++; $display("FAIL hand_adr: got adr=%h abort=%b expected 30000000 0", s_adr, abort); end
    step;
    m1_stb = 1'b0; s_ack = 1'b1; s_rdat = 32'h66;
    #1;
    checks++; if (m1_ack !== 1'b1 || m1_rdat !== 32'h66 || m0_ack !== 1'b0) begin errors++; $display("FAIL hand_ack: got m1_ack=%b dat=%h m0_ack=%b expected 1 66 0", m1_ack, m1_rdat, m0_ack); end
    step;
    s_ack = 1'b0; m1_cyc = 1'b0;
    step;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL hand_release: got %b expected 00", grant); end
  endtask

  task automatic test_throttle;
    step;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h4000_0000;
    step;
    step;
    m0_adr = 32'h4000_0004;
    #1;
    checks++; if (m0_stall !== 1'b0 || s_stb !== 1'b1) begin errors++; $display("FAIL thr_second: got stall=%b stb=%b expected 0 1", m0_stall, s_stb); end
    step;
    m0_adr = 32'h4000_0008;
    #1;
    checks++; if (m0_stall !== 1'b1 || s_stb !== 1'b0) begin errors++; $display("FAIL thr_third: got stall=%b stb=%b expected 1 0", m0_stall, s_stb); end
    step;
    s_ack = 1'b1; s_rdat = 32'h70;
    #1;
    checks++; if (m0_stall !== 1'b1 || s_stb !== 1'b0 || m0_ack !== 1'b1) begin errors++; $display("FAIL thr_hold: got stall=%b stb=%b ack=%b expected 1 0 1", m0_stall, s_stb, m0_ack); end
    step;
    s_ack = 1'b0;
    #1;
    checks++; if (m0_stall !== 1'b0 || s_stb !== 1'b1 || s_adr !== 32'h4000_0008) begin errors++; $display("FAIL thr_release: got stall=%b stb=%b adr=%h expected 0 1 40000008", m0_stall, s_stb, s_adr); end
    step;
    m0_stb = 1'b0; s_ack = 1'b1;
    step;
    step;
    s_ack = 1'b0; m0_cyc = 1'b0;
    step;
    checks++; if (grant !== 2'b00 || abort !== 1'b0) begin errors++; $display("FAIL thr_end: got grant=%b abort=%b expected 00 0", grant, abort); end
  endtask

  task automatic test_abort;
    step;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h5000_0000;
    step;
    step;
    m0_stb = 1'b0; m0_cyc = 1'b0;
    step;
    s_ack = 1'b1; s_rdat = 32'hBAD;
    #1;
    checks++; if (abort !== 1'b1 || grant !== 2'b00) begin errors++; $display("FAIL abort_pulse: got abort=%b grant=%b expected 1 00", abort, grant); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL abort_late_ack: got m0=%b m1=%b expected 0 0", m0_ack, m1_ack); end
    step;
    s_ack = 1'b0;
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL abort_once: got %b expected 0", abort); end
  endtask

  task automatic test_timeout_reset;
    step;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h6000_0000;
    step;
    step;
    m0_stb = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step;
      checks++; if (timeout !== (i == 8)) begin errors++; $display("FAIL tmo_cycle[%0d]: got %b expected %b", i, timeout, i == 8); end
    end
    step;
    checks++; if (timeout !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL tmo_after: got timeout=%b grant=%b expected 0 01", timeout, grant); end
    m1_cyc = 1'b1; s_ack = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || s_cyc !== 1'b0 || s_adr !== 32'd0) begin errors++; $display("FAIL async_reset: got grant=%b cyc=%b adr=%h expected 00 0 0", grant, s_cyc, s_adr); end
    checks++; if ({m0_stall, m1_stall, m0_ack, m1_ack} !== 4'b1100) begin errors++; $display("FAIL async_reset_resp: got %b expected 1100", {m0_stall, m1_stall, m0_ack, m1_ack}); end
    step;
    checks++; if (abort !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_no_abort: got abort=%b timeout=%b expected 0 0", abort, timeout); end
    m0_cyc = 1'b0; m1_cyc = 1'b0; s_ack = 1'b0;
    rst_n = 1'b1;
    step;
    step;
    checks++; if (abort !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL post_reset: got abort=%b grant=%b expected 0 00", abort, grant); end
  endtask

  initial begin
    rst_n = 1'b0;
    m0_adr = 32'd0; m0_wdat = 32'd0; m0_sel = 4'd0; m0_we = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_adr = 32'd0; m1_wdat = 32'd0; m1_sel = 4'd0; m1_we = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_rdat = 32'd0; s_ack = 1'b0; s_stall = 1'b0;
    test_reset;
    test_arbitration;
    test_single;
    test_handover;
    test_throttle;
    test_abort;
    test_timeout_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
